// File: rtl/fifo_read_port_pkg.sv
// ============================================================================
// Module      : fifo_read_port_pkg
// Description : Shared FSM state type and parameter defaults for fifo_read_port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_read_port_pkg;

  localparam int DATA_W_DEFAULT = 4;
  localparam int CNT_W_DEFAULT  = 9;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_POP     = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/Bin2Seg.sv
// ============================================================================
// Module      : Bin2Seg
// Description : 4-bit binary to active-low seven-segment decoder (gfedcba).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module Bin2Seg (
  input  logic [3:0] bin,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (bin)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fifo_read_port.sv
// ============================================================================
// Module      : fifo_read_port
// Description : Push-key driven FIFO read port with word counter and 7-seg
//               display. Define FIFO_READ_PORT_SHOWAHEAD_EN for show-ahead FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_read_port
  import fifo_read_port_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rdbtn,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_q,
  output logic              fifo_rdreq,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              underflow,
  output logic [CNT_W-1:0]  rd_count,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3
);

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [1:0]        fill_q, fill_d;
  logic              armed_q, armed_d;
  logic              rdreq_q, rdreq_d, valid_q, valid_d, uflow_q, uflow_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [3:0]        ones_q, ones_d, tens_q, tens_d, hund_q, hund_d;
  logic [31:0]       count_ext;
  logic              req;

  // Edge detection stays disarmed until the synchroniser has filled and shown
  // the key released, so a key held through reset never fires.
  always_comb begin
    sync1_d = rdbtn;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & ~sync2_q);
    req     = sync2_q & ~prev_q & armed_q;
  end

  always_comb begin
    state_d = state_q;
    rdreq_d = 1'b0;
    valid_d = 1'b0;
    uflow_d = 1'b0;
    dout_d  = dout_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (fifo_empty) begin
            uflow_d = 1'b1;
          end else begin
            state_d = S_POP;
            rdreq_d = 1'b1;
`ifdef FIFO_READ_PORT_SHOWAHEAD_EN
            dout_d  = fifo_q;
`endif
          end
        end
      end
      S_POP: begin
`ifdef FIFO_READ_PORT_SHOWAHEAD_EN
        state_d = S_CAPTURE;
        valid_d = 1'b1;
        count_d = count_q + CNT_W'(1);
`else
        state_d = S_WAIT;
`endif
      end
      S_WAIT: begin
        // Read data is valid here after the one-cycle BRAM latency.
        state_d = S_CAPTURE;
        dout_d  = fifo_q;
        valid_d = 1'b1;
        count_d = count_q + CNT_W'(1);
      end
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_ext = 32'(count_q);
    ones_d    = 4'(count_ext % 32'd10);
    tens_d    = 4'((count_ext / 32'd10) % 32'd10);
    hund_d    = 4'(count_ext / 32'd100);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      rdreq_q <= 1'b0;
      valid_q <= 1'b0;
      uflow_q <= 1'b0;
      dout_q  <= '0;
      count_q <= '0;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      hund_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
      rdreq_q <= rdreq_d;
      valid_q <= valid_d;
      uflow_q <= uflow_d;
      dout_q  <= dout_d;
      count_q <= count_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      hund_q  <= hund_d;
    end
  end

  assign fifo_rdreq = rdreq_q;
  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign underflow  = uflow_q;
  assign rd_count   = count_q;

  Bin2Seg u_hex0 (.bin(dout_q[3:0]), .seg(HEX0));
  Bin2Seg u_hex1 (.bin(ones_q),      .seg(HEX1));
  Bin2Seg u_hex2 (.bin(tens_q),      .seg(HEX2));
  Bin2Seg u_hex3 (.bin(hund_q),      .seg(HEX3));

endmodule

`default_nettype wire

// File: tb/tb_fifo_read_port.sv
// ============================================================================
// Module      : tb_fifo_read_port
// Description : Directed self-checking bench for fifo_read_port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_read_port;

  logic       clk = 1'b0;
  logic       reset, rdbtn, fifo_empty;
  logic [3:0] fifo_q;
  logic       fifo_rdreq, data_valid, underflow;
  logic [3:0] data_out;
  logic [8:0] rd_count;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;

  fifo_read_port dut (
    .clk(clk), .reset(reset), .rdbtn(rdbtn), .fifo_empty(fifo_empty),
    .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq), .data_out(data_out),
    .data_valid(data_valid), .underflow(underflow), .rd_count(rd_count),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  always #5 clk = ~clk;

`ifdef FIFO_READ_PORT_SHOWAHEAD_EN
  localparam int DV_IDX = 4;
  localparam int RST_AT = 3;
`else
  localparam int DV_IDX = 5;
  localparam int RST_AT = 4;
`endif

  int errors = 0;
  int checks = 0;
  int rq_cnt, rq_idx, dv_cnt, dv_idx, uf_cnt, uf_idx;
  logic [3:0] dout_at_rq;
  logic [8:0] rst_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives rdbtn from pat (one bit per cycle, set on the falling edge) and
  // records when strobes appear; sample k is taken k falling edges later.
  task automatic run(input logic [15:0] pat, input int n, input int rst_at);
    rq_cnt = 0; rq_idx = -1; dv_cnt = 0; dv_idx = -1; uf_cnt = 0; uf_idx = -1;
    dout_at_rq = 4'hx;
    for (int i = 0; i < n; i++) begin
      rdbtn = pat[i];
      if (rst_at >= 0 && i == rst_at) begin
        reset = 1'b1;
        #1 rst_cnt = rd_count;
      end
      if (rst_at >= 0 && i == rst_at + 2) reset = 1'b0;
      @(negedge clk);
      if (fifo_rdreq) begin
        if (rq_cnt == 0) begin rq_idx = i + 1; dout_at_rq = data_out; end
        rq_cnt++;
      end
      if (data_valid) begin
        if (dv_cnt == 0) dv_idx = i + 1;
        dv_cnt++;
      end
      if (underflow) begin
        if (uf_cnt == 0) uf_idx = i + 1;
        uf_cnt++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; rdbtn = 1'b0; fifo_empty = 1'b0; fifo_q = 4'h0;
    rst_cnt = '0;
    repeat (2) @(negedge clk);
    check("rst_rdreq", fifo_rdreq, 0);
    check("rst_dout",  data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_uflow", underflow, 0);
    check("rst_count", rd_count, 0);
    check("rst_hex0",  HEX0, 7'h40);
    check("rst_hex3",  HEX3, 7'h40);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Basic pop of 4'hA
    fifo_q = 4'hA;
    run(16'h003F, 12, -1);
    check("pop_rq_cnt", rq_cnt, 1);
    check("pop_rq_idx", rq_idx, 3);
    check("pop_dv_cnt", dv_cnt, 1);
    check("pop_dv_idx", dv_idx, DV_IDX);
    check("pop_dout",   data_out, 4'hA);
    check("pop_count",  rd_count, 1);
    check("pop_uflow",  uf_cnt, 0);
    check("pop_hex0",   HEX0, 7'h08);
    check("pop_hex1",   HEX1, 7'h79);
`ifdef FIFO_READ_PORT_SHOWAHEAD_EN
    check("pop_dout_at_rq", dout_at_rq, 4'hA);
`else
    check("pop_dout_at_rq", dout_at_rq, 4'h0);
`endif

    // Request on an empty FIFO
    fifo_empty = 1'b1; fifo_q = 4'h5;
    run(16'h003F, 12, -1);
    check("uf_cnt",    uf_cnt, 1);
    check("uf_idx",    uf_idx, 3);
    check("uf_rq_cnt", rq_cnt, 0);
    check("uf_dv_cnt", dv_cnt, 0);
    check("uf_count",  rd_count, 1);
    check("uf_dout",   data_out, 4'hA);
    fifo_empty = 1'b0;

    // Second edge lands while the pop is in flight and must be dropped
    fifo_q = 4'h3;
    run(16'h003D, 12, -1);
    check("dbl_rq_cnt", rq_cnt, 1);
    check("dbl_dv_cnt", dv_cnt, 1);
    check("dbl_dout",   data_out, 4'h3);
    check("dbl_count",  rd_count, 2);

    // Reset mid-pop aborts it; rd_count clears asynchronously
    fifo_q = 4'h7;
    run(16'h003F, 12, RST_AT);
    check("mid_rst_async_count", rst_cnt, 0);
    check("mid_rst_rq_cnt", rq_cnt, 1);
    check("mid_rst_dv_cnt", dv_cnt, 0);
    check("mid_rst_count",  rd_count, 0);
    check("mid_rst_dout",   data_out, 0);
    repeat (4) @(negedge clk);
    fifo_q = 4'h9;
    run(16'h003F, 12, -1);
    check("post_rst_dv_cnt", dv_cnt, 1);
    check("post_rst_dout",   data_out, 4'h9);
    check("post_rst_count",  rd_count, 1);

    // Key held through reset release produces no request
    reset = 1'b1; rdbtn = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    fifo_q = 4'h2;
    run(16'h00FF, 12, -1);
    check("held_rq_cnt", rq_cnt, 0);
    check("held_count",  rd_count, 0);
    run(16'h003F, 12, -1);
    check("held_next_rq_cnt", rq_cnt, 1);
    check("held_next_dout",   data_out, 4'h2);
    check("held_next_count",  rd_count, 1);

    // Count up to 511 then wrap
    fifo_q = 4'hF;
    for (int j = 0; j < 510; j++) run(16'h003F, 12, -1);
    check("max_count", rd_count, 9'd511);
    check("max_hex1",  HEX1, 7'h79);
    check("max_hex2",  HEX2, 7'h79);
    check("max_hex3",  HEX3, 7'h12);
    run(16'h003F, 12, -1);
    check("wrap_count", rd_count, 0);
    check("wrap_hex1",  HEX1, 7'h40);
    check("wrap_hex2",  HEX2, 7'h40);
    check("wrap_hex3",  HEX3, 7'h40);
    check("wrap_hex0",  HEX0, 7'h0E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
